// File: rtl/add_1bit_vector_checker.sv
// Self-contained stimulus/checker for a 1-bit adder: drives a fixed table of
// {a,b} vectors, samples the sum c after a settle time and tallies the results.
module add_1bit_vector_checker #(
    parameter int WARMUP_CYC = 10,
    parameter int SETTLE_CYC = 1,
    parameter int DRAIN_CYC  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       c,
    output logic       a,
    output logic       b,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] pass_cnt,
    output logic [3:0] fail_cnt,
    output logic [6:0] fail_mask,
    output logic [2:0] vec_idx
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WARMUP,
        S_DRIVE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd6;

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [3:0] r_pass_cnt;
    logic [3:0] r_fail_cnt;
    logic [6:0] r_fail_mask;
    logic [2:0] r_vec_idx;

    logic [2:0] w_next_idx;
    logic [2:0] w_cur_vec;
    logic [2:0] w_next_vec;
    logic [2:0] w_first_vec;
    logic       w_match;

    // Each entry packs {a, b, expected sum}.
    function automatic logic [2:0] vec_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    vec_entry = 3'b000;
            3'd1:    vec_entry = 3'b011;
            3'd2:    vec_entry = 3'b101;
            3'd3:    vec_entry = 3'b110;
            3'd4:    vec_entry = 3'b011;
            3'd5:    vec_entry = 3'b101;
            3'd6:    vec_entry = 3'b110;
            default: vec_entry = 3'b000;
        endcase
    endfunction

    assign w_next_idx  = r_vec_idx + 3'd1;
    assign w_cur_vec   = vec_entry(r_vec_idx);
    assign w_next_vec  = vec_entry(w_next_idx);
    assign w_first_vec = vec_entry(3'd0);
    assign w_match     = (c == w_cur_vec[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_pass_cnt  <= 4'd0;
            r_fail_cnt  <= 4'd0;
            r_fail_mask <= 7'd0;
            r_vec_idx   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state     <= S_WARMUP;
                        r_cnt       <= 8'(WARMUP_CYC - 1);
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_pass_cnt  <= 4'd0;
                        r_fail_cnt  <= 4'd0;
                        r_fail_mask <= 7'd0;
                        r_vec_idx   <= 3'd0;
                    end
                end
                S_WARMUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_DRIVE;
                        r_cnt   <= 8'(SETTLE_CYC - 1);
                        r_a     <= w_first_vec[2];
                        r_b     <= w_first_vec[1];
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DRIVE: begin
                    if (r_cnt == 8'd0) begin
                        // Sampling edge: score this vector and move straight on.
                        if (w_match) begin
                            r_pass_cnt <= r_pass_cnt + 4'd1;
                        end else begin
                            r_fail_cnt             <= r_fail_cnt + 4'd1;
                            r_fail_mask[r_vec_idx] <= 1'b1;
                        end
                        if (r_vec_idx == LAST_IDX) begin
                            r_state <= S_DRAIN;
                            r_cnt   <= 8'(DRAIN_CYC - 1);
                        end else begin
                            r_vec_idx <= w_next_idx;
                            r_a       <= w_next_vec[2];
                            r_b       <= w_next_vec[1];
                            r_cnt     <= 8'(SETTLE_CYC - 1);
                        end
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (r_fail_cnt == 4'd0);
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign a         = r_a;
    assign b         = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign pass_cnt  = r_pass_cnt;
    assign fail_cnt  = r_fail_cnt;
    assign fail_mask = r_fail_mask;
    assign vec_idx   = r_vec_idx;

endmodule

// File: tb/tb_add_1bit_vector_checker.sv
// Directed bench: checker runs against ideal, stuck, inverted and registered adder models.
module tb_add_1bit_vector_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start2;
    logic       c, c2;
    logic       a, b, busy, done, pass;
    logic       a2, b2, busy2, done2, pass2;
    logic [3:0] pcnt, fcnt, pcnt2, fcnt2;
    logic [6:0] mask, mask2;
    logic [2:0] idx, idx2;
    logic       r_creg, r_creg2;
    int         mode;
    int         n_chk = 0;
    int         n_err = 0;
    int         lat;

    always #5 clk = ~clk;

    add_1bit_vector_checker u_dut (
        .clk(clk), .rst(rst), .start(start), .c(c),
        .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
        .pass_cnt(pcnt), .fail_cnt(fcnt), .fail_mask(mask), .vec_idx(idx)
    );

    add_1bit_vector_checker #(.SETTLE_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .c(c2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
        .pass_cnt(pcnt2), .fail_cnt(fcnt2), .fail_mask(mask2), .vec_idx(idx2)
    );

    // Adder models: 0 ideal, 1 stuck-at-0, 2 inverted, 3 one register stage.
    always @(posedge clk) begin
        r_creg  <= a ^ b;
        r_creg2 <= a2 ^ b2;
    end

    always_comb begin
        c = 1'b0;
        case (mode)
            0:       c = a ^ b;
            1:       c = 1'b0;
            2:       c = ~(a ^ b);
            default: c = r_creg;
        endcase
    end

    assign c2 = r_creg2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string t);
        check({t, "_ab"},    {30'd0, a, b}, 32'd0);
        check({t, "_flags"}, {29'd0, busy, done, pass}, 32'd0);
        check({t, "_cnts"},  {24'd0, pcnt, fcnt}, 32'd0);
        check({t, "_mask"},  {25'd0, mask}, 32'd0);
        check({t, "_idx"},   {29'd0, idx}, 32'd0);
    endtask

    // Pulses start, then counts edges after T0 until done (bounded).
    task automatic run(input int sel, input int extra_start, input int rst_at,
                       input bit trace, output int latency);
        latency = 0;
        if (sel == 1) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; start2 = 1'b0;
        if (sel == 1) begin
            check("t0_busy2", {31'd0, busy2}, 32'd1);
            check("t0_clr2",  {17'd0, done2, pcnt2, fcnt2, mask2, idx2}, 32'd0);
        end else begin
            check("t0_busy", {31'd0, busy}, 32'd1);
            check("t0_clr",  {17'd0, done, pcnt, fcnt, mask, idx}, 32'd0);
        end
        for (int n = 1; n <= 80; n++) begin
            if (n == extra_start) start = 1'b1;
            if (n == rst_at) rst = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            if (n == rst_at) begin
                rst = 1'b0;
                latency = -1;
                return;
            end
            if (trace) begin
                if (n == 10) check("tr10", {28'd0, a, b, idx}, 32'b00_000);
                if (n == 11) check("tr11", {28'd0, a, b, idx}, 32'b01_001);
                if (n == 12) check("tr12", {28'd0, a, b, idx}, 32'b10_010);
                if (n == 16) check("tr16", {28'd0, a, b, idx}, 32'b11_110);
                if (n == 20) check("tr20", {26'd0, a, b, idx, busy, done}, 32'b11_110_10);
            end
            if ((sel == 1) ? done2 : done) begin
                latency = n;
                return;
            end
        end
    endtask

    task automatic check_res(input string t, input int sel, input int lat_got, input int lat_exp,
                             input logic pass_e, input logic [3:0] pc_e, input logic [3:0] fc_e,
                             input logic [6:0] mask_e);
        check({t, "_lat"}, lat_got, lat_exp);
        if (sel == 1) begin
            check({t, "_busy_pass"}, {30'd0, busy2, pass2}, {30'd0, 1'b0, pass_e});
            check({t, "_cnts"}, {24'd0, pcnt2, fcnt2}, {24'd0, pc_e, fc_e});
            check({t, "_mask"}, {25'd0, mask2}, {25'd0, mask_e});
        end else begin
            check({t, "_busy_pass"}, {30'd0, busy, pass}, {30'd0, 1'b0, pass_e});
            check({t, "_cnts"}, {24'd0, pcnt, fcnt}, {24'd0, pc_e, fc_e});
            check({t, "_mask"}, {25'd0, mask}, {25'd0, mask_e});
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0; mode = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        mode = 0;
        run(0, 0, 0, 1'b1, lat);
        check_res("ideal", 0, lat, 27, 1'b1, 4'd7, 4'd0, 7'b0000000);
        repeat (5) @(posedge clk);
        #1;
        check("done_hold", {16'd0, done, pass, pcnt, fcnt, mask, a, b}, {16'd0, 1'b1, 1'b1, 4'd7, 4'd0, 7'd0, 1'b1, 1'b1});

        mode = 1;
        run(0, 0, 0, 1'b0, lat);
        check_res("stuck0", 0, lat, 27, 1'b0, 4'd3, 4'd4, 7'b0110110);

        mode = 2;
        run(0, 0, 0, 1'b0, lat);
        check_res("invert", 0, lat, 27, 1'b0, 4'd0, 4'd7, 7'b1111111);

        mode = 0;
        run(0, 0, 0, 1'b1, lat);
        check_res("rerun", 0, lat, 27, 1'b1, 4'd7, 4'd0, 7'b0000000);

        mode = 3;
        run(0, 0, 0, 1'b0, lat);
        check_res("reg_s1", 0, lat, 27, 1'b0, 4'd3, 4'd4, 7'b1011010);

        mode = 0;
        run(0, 5, 0, 1'b0, lat);
        check_res("start_busy", 0, lat, 27, 1'b1, 4'd7, 4'd0, 7'b0000000);

        mode = 2;
        run(0, 0, 15, 1'b0, lat);
        check("rst_mid_lat", lat, -1);
        check_reset("rst_mid");

        mode = 0;
        run(0, 0, 0, 1'b0, lat);
        check_res("after_rst", 0, lat, 27, 1'b1, 4'd7, 4'd0, 7'b0000000);

        run(1, 0, 0, 1'b0, lat);
        check_res("reg_s2", 1, lat, 34, 1'b1, 4'd7, 4'd0, 7'b0000000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
